// File: rtl/parser_pkg.sv
// Shared widths, address fields and config types for the parser chain.
// Layer-0 extraction config is the cfg0_t struct; layer_info_t is one link of the chain.
package parser_pkg;

    localparam int HEAD_WIDTH    = 64;
    localparam int META_WIDTH    = 32;
    localparam int TAG_WIDTH     = 4;
    localparam int TAG_VALID_BIT = 0;
    localparam int TAG_START_BIT = 1;
    localparam int TAG_TAIL_BIT  = 2;

    localparam int TYPE_NUM          = 4;
    localparam int KEY_FILED_NUM     = 4;
    localparam int TYPE_OFFSET_WIDTH = 8;
    localparam int KEY_OFFSET_WIDTH  = 16;
    localparam int HEAD_SHIFT_WIDTH  = 8;
    localparam int META_SHIFT_WIDTH  = 8;
    localparam int TYPE_IDX_W        = $clog2(TYPE_NUM);
    localparam int KEY_IDX_W         = $clog2(KEY_FILED_NUM);
    localparam int KEY_V_BIT         = 16;

    localparam int LAYER_ID_HI  = 31;
    localparam int LAYER_ID_LO  = 24;
    localparam int INFO_TYPE_HI = 18;
    localparam int INFO_TYPE_LO = 16;
    localparam int EXTR_ID_HI   = 7;
    localparam int EXTR_ID_LO   = 0;

    typedef enum logic [2:0] {
        INFO_TYPE_OFFSET = 3'd2,
        INFO_KEY_OFFSET  = 3'd3,
        INFO_HEAD_SHIFT  = 3'd4,
        INFO_META_SHIFT  = 3'd5
    } info_type_e;

    typedef enum logic {PKT_IDLE, PKT_IN} pkt_state_e;

    typedef struct packed {
        logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]     type_offset;
        logic [KEY_FILED_NUM-1:0]                       key_offset_v;
        logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0] key_offset;
        logic [HEAD_SHIFT_WIDTH-1:0]                    head_shift;
        logic [META_SHIFT_WIDTH-1:0]                    meta_shift;
    } cfg0_t;

    typedef struct packed {
        logic [HEAD_WIDTH+TAG_WIDTH-1:0] head;
        logic [META_WIDTH+TAG_WIDTH-1:0] meta;
        cfg0_t                           cfg;
    } layer_info_t;

    // Shift-type fields have a single instance, so their extract ID is don't-care.
    function automatic logic cfg0_addr_ok(input logic [2:0] info_type, input logic [7:0] extr_id);
        logic ok;
        ok = 1'b0;
        case (info_type)
            INFO_TYPE_OFFSET:                ok = (extr_id < 8'(TYPE_NUM));
            INFO_KEY_OFFSET:                 ok = (extr_id < 8'(KEY_FILED_NUM));
            INFO_HEAD_SHIFT, INFO_META_SHIFT: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] cfg0_read(input cfg0_t cfg, input logic [2:0] info_type,
                                              input logic [7:0] extr_id);
        logic [31:0] r;
        r = '0;
        if (cfg0_addr_ok(info_type, extr_id)) begin
            case (info_type)
                INFO_TYPE_OFFSET: r[TYPE_OFFSET_WIDTH-1:0] = cfg.type_offset[extr_id[TYPE_IDX_W-1:0]];
                INFO_KEY_OFFSET: begin
                    r[KEY_V_BIT]              = cfg.key_offset_v[extr_id[KEY_IDX_W-1:0]];
                    r[KEY_OFFSET_WIDTH-1:0]   = cfg.key_offset[extr_id[KEY_IDX_W-1:0]];
                end
                INFO_HEAD_SHIFT:  r[HEAD_SHIFT_WIDTH-1:0] = cfg.head_shift;
                INFO_META_SHIFT:  r[META_SHIFT_WIDTH-1:0] = cfg.meta_shift;
                default:          r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/parser_rule_if.sv
// Rule configuration bus: write/read strobes, address, data and read return.
interface parser_rule_if;
    logic        wren;
    logic        rden;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic [31:0] rdata;

    modport master (output wren, rden, addr, wdata, input rdata_valid, rdata);
    modport slave  (input wren, rden, addr, wdata, output rdata_valid, rdata);
endinterface

// File: rtl/parser_cfg0_regs.sv
// Shadow/active extraction config: writes land in shadow, i_commit copies shadow to active.
// Readback is combinational from the active copy.
module parser_cfg0_regs
    import parser_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wren,
    input  logic [2:0]  i_info_type,
    input  logic [7:0]  i_extr_id,
    input  logic [31:0] i_wdata,
    input  logic        i_commit,
    output logic        o_pending,
    output cfg0_t       o_active,
    output logic [31:0] o_rd_data
);

    cfg0_t shadow_q, shadow_d, active_q;
    logic  pending_q;
    logic  wr_ok;
    logic  unused_wdata;

    assign wr_ok        = i_wren && cfg0_addr_ok(i_info_type, i_extr_id);
    assign unused_wdata = ^i_wdata[31:KEY_V_BIT+1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_ok) begin
            case (i_info_type)
                INFO_TYPE_OFFSET:
                    shadow_d.type_offset[i_extr_id[TYPE_IDX_W-1:0]] = i_wdata[TYPE_OFFSET_WIDTH-1:0];
                INFO_KEY_OFFSET: begin
                    shadow_d.key_offset_v[i_extr_id[KEY_IDX_W-1:0]] = i_wdata[KEY_V_BIT];
                    shadow_d.key_offset[i_extr_id[KEY_IDX_W-1:0]]   = i_wdata[KEY_OFFSET_WIDTH-1:0];
                end
                INFO_HEAD_SHIFT: shadow_d.head_shift = i_wdata[HEAD_SHIFT_WIDTH-1:0];
                INFO_META_SHIFT: shadow_d.meta_shift = i_wdata[META_SHIFT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // NOTE: non-blocking assignments so the commit reads the pre-write shadow.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (i_commit) active_q <= shadow_q;
            if (wr_ok)         pending_q <= 1'b1;
            else if (i_commit) pending_q <= 1'b0;
        end
    end

    assign o_pending = pending_q;
    assign o_active  = active_q;
    assign o_rd_data = cfg0_read(active_q, i_info_type, i_extr_id);

endmodule

// File: rtl/parser_layer.sv
// One parser stage: strips head/meta bytes per incoming config, one cycle of latency,
// and holds its own rules (applied at once) which it hands on as the next stage's config.
module Parser_Layer
    import parser_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    parser_rule_if.slave  rule,
    input  layer_info_t   i_info,
    output layer_info_t   o_info
);

    logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_q;
    logic [META_WIDTH+TAG_WIDTH-1:0] meta_q;
    cfg0_t       active;
    logic        pending;
    logic [31:0] rd_data;
    logic        rd_valid_q;
    logic [31:0] rd_data_q;
    logic        unused_addr;

    assign unused_addr = ^{rule.addr[31:INFO_TYPE_HI+1], rule.addr[INFO_TYPE_LO-1:EXTR_ID_HI+1]};

    parser_cfg0_regs u_rules (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wren      (rule.wren),
        .i_info_type (rule.addr[INFO_TYPE_HI:INFO_TYPE_LO]),
        .i_extr_id   (rule.addr[EXTR_ID_HI:EXTR_ID_LO]),
        .i_wdata     (rule.wdata),
        .i_commit    (pending),
        .o_pending   (pending),
        .o_active    (active),
        .o_rd_data   (rd_data)
    );

    // NOTE: pipeline data carries no reset; only control state is cleared.
    always_ff @(posedge i_clk) begin
        head_q <= {i_info.head[HEAD_WIDTH +: TAG_WIDTH],
                   i_info.head[HEAD_WIDTH-1:0] << {i_info.cfg.head_shift, 3'b000}};
        meta_q <= {i_info.meta[META_WIDTH +: TAG_WIDTH],
                   i_info.meta[META_WIDTH-1:0] << {i_info.cfg.meta_shift, 3'b000}};
    end

    // Read data is zero outside the valid pulse so the top can OR all stages.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rule.rden;
            rd_data_q  <= rule.rden ? rd_data : '0;
        end
    end

    assign rule.rdata_valid = rd_valid_q;
    assign rule.rdata       = rd_data_q;
    assign o_info           = '{head: head_q, meta: meta_q, cfg: active};

endmodule

// File: rtl/parser_top_n.sv
// Parametrised parser top: LAYER_NUM chained layers, layer-0 config committed at
// packet boundaries, packet framing statistics and rule readback from every layer.
module parser_top_n
    import parser_pkg::*;
#(
    parameter int LAYER_NUM = 3,
    parameter int CNT_WIDTH = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_rule_wren,
    input  logic                            i_rule_rden,
    input  logic [31:0]                     i_rule_addr,
    input  logic [31:0]                     i_rule_wdata,
    output logic                            o_rule_rdata_valid,
    output logic [31:0]                     o_rule_rdata,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
    output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
    output logic                            o_cfg_pending,
    output logic [CNT_WIDTH-1:0]            o_pkt_cnt,
    output logic [CNT_WIDTH-1:0]            o_err_cnt
);

    logic [7:0] layer_id;
    logic       l0_hit, lyr_hit;
    logic       slice_valid, slice_start, slice_tail;

    pkt_state_e state_q, state_d;
    logic       pkt_inc, err_inc, commit;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, err_cnt_q;

    cfg0_t       active;
    logic        pending;
    logic [31:0] cfg0_rd_data;

    layer_info_t layer_info [LAYER_NUM+1];
    logic        stage_valid_v [LAYER_NUM];
    logic [31:0] stage_data_v  [LAYER_NUM];
    logic        stage_valid;
    logic [31:0] stage_data;
    logic        own_rd, own_valid_q;
    logic [31:0] rdata_q;
    logic        unused_cfg;

    assign layer_id    = i_rule_addr[LAYER_ID_HI:LAYER_ID_LO];
    assign l0_hit      = (layer_id == 8'd0);
    assign lyr_hit     = !l0_hit && (layer_id <= 8'(LAYER_NUM));
    assign slice_valid = i_head[HEAD_WIDTH+TAG_VALID_BIT];
    assign slice_start = i_head[HEAD_WIDTH+TAG_START_BIT];
    assign slice_tail  = i_head[HEAD_WIDTH+TAG_TAIL_BIT];

    // A start with no preceding tail is counted as an error and then adopted.
    always_comb begin
        state_d = state_q;
        pkt_inc = 1'b0;
        err_inc = 1'b0;
        if (slice_valid) begin
            case (state_q)
                PKT_IDLE: begin
                    if (!slice_start)    err_inc = 1'b1;
                    else if (slice_tail) pkt_inc = 1'b1;
                    else                 state_d = PKT_IN;
                end
                PKT_IN: begin
                    if (slice_start) err_inc = 1'b1;
                    if (slice_tail) begin
                        pkt_inc = 1'b1;
                        state_d = PKT_IDLE;
                    end
                end
                default: state_d = PKT_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= PKT_IDLE;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (pkt_inc) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
            if (err_inc) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign commit = pending && (state_q == PKT_IDLE) && !slice_valid;

    parser_cfg0_regs u_cfg0 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wren      (i_rule_wren && l0_hit),
        .i_info_type (i_rule_addr[INFO_TYPE_HI:INFO_TYPE_LO]),
        .i_extr_id   (i_rule_addr[EXTR_ID_HI:EXTR_ID_LO]),
        .i_wdata     (i_rule_wdata),
        .i_commit    (commit),
        .o_pending   (pending),
        .o_active    (active),
        .o_rd_data   (cfg0_rd_data)
    );

    assign layer_info[0] = '{head: i_head, meta: i_meta, cfg: active};

    for (genvar k = 1; k <= LAYER_NUM; k++) begin : g_layer
        parser_rule_if bus ();

        assign bus.wren  = i_rule_wren && (layer_id == 8'(k));
        assign bus.rden  = i_rule_rden && (layer_id == 8'(k));
        assign bus.addr  = i_rule_addr;
        assign bus.wdata = i_rule_wdata;

        Parser_Layer u_layer (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .rule    (bus.slave),
            .i_info  (layer_info[k-1]),
            .o_info  (layer_info[k])
        );

        assign stage_valid_v[k-1] = bus.rdata_valid;
        assign stage_data_v[k-1]  = bus.rdata;
    end

    always_comb begin
        stage_valid = 1'b0;
        stage_data  = '0;
        for (int k = 0; k < LAYER_NUM; k++) begin
            stage_valid = stage_valid | stage_valid_v[k];
            stage_data  = stage_data | stage_data_v[k];
        end
    end

    // Layer-0 and unroutable reads answer here; rdata_q also holds the last returned word.
    assign own_rd = i_rule_rden && !lyr_hit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            own_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            own_valid_q <= own_rd;
            if (own_rd)           rdata_q <= l0_hit ? cfg0_rd_data : '0;
            else if (stage_valid) rdata_q <= stage_data;
        end
    end

    assign o_rule_rdata_valid = own_valid_q | stage_valid;
    assign o_rule_rdata       = stage_valid ? stage_data : rdata_q;
    assign o_cfg_pending      = pending;
    assign o_pkt_cnt          = pkt_cnt_q;
    assign o_err_cnt          = err_cnt_q;
    assign o_head             = layer_info[LAYER_NUM].head;
    assign o_meta             = layer_info[LAYER_NUM].meta;
    assign unused_cfg         = ^layer_info[LAYER_NUM].cfg;

endmodule
